blink_array: RTL and testbench
==============================

// Module: blink_array
// PURPOSE
//  N-channel LED blinker, one output per channel. Each channel has its own mode and half-period in ms.
//  One shared ms prescaler drives all channels. A synchronised, edge-detected pushbutton loads the
//  switch settings into the selected channel. Sits between board pushbuttons/switches and LEDG/LEDR.
// PARAMETERS
//  CLK_HZ      50_000_000  clock frequency; TICK_DIV = CLK_HZ/1000 cycles per ms tick
//  N_CH        4           number of LED channels (>=1); CH_W = max(1,$clog2(N_CH))
//  PER_W       14          half-period width in ms
//  DEBOUNCE_MS 8           stable time for key accept (used only with BLINK_DEBOUNCE_EN)
// PORTS
//  clk         in   1      system clock (CLOCK_50)
//  rst         in   1      asynchronous reset, active-high
//  key_load_n  in   1      raw pushbutton, active-low, asynchronous to clk
//  sel         in   CH_W   channel to load; values >= N_CH are ignored (load dropped)
//  mode        in   2      00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
//  period      in   PER_W  half-period / pulse width in ms; 0 is treated as 1
//  led         out  N_CH   channel outputs
//  tick_ms     out  1      one-cycle pulse every TICK_DIV cycles
//  load_ack    out  1      one-cycle pulse when a load is accepted by a valid channel
// BEHAVIOUR
//  Reset: all outputs 0; prescaler 0; all channels OFF with active/pending period 1 and ms count 0.
//  Prescaler: counts 0..TICK_DIV-1 and wraps. tick_ms=1 in the cycle the count equals TICK_DIV-1.
//  Key path: 2-flop synchroniser, then a falling-edge detect.
//    load fires 3 cycles after key_load_n first samples low. A held key gives exactly one load.
//  Load (cycle L): sel, mode and period are sampled in cycle L. load_ack=1 in cycle L+1 if sel<N_CH.
//    The selected channel's pending_mode/pending_period update at the L+1 edge.
//  Channel, when the mode changes (pending_mode != active mode), applied at the next edge:
//    ms count cleared; active_period = pending_period.
//    OFF -> led=0. ON -> led=1.
//    BLINK -> led=1; led toggles on the tick where count==active_period-1, then count returns to 0.
//    ONESHOT -> led=1 for active_period ticks, then led=0 and active mode becomes OFF (self-clearing).
//  Same-mode reload:
//    BLINK: the period is adopted only at the next toggle. The current phase completes with the old period.
//    ONESHOT: restarts the pulse, count cleared.
//    OFF/ON: no visible change.
//  Load and toggle in the same cycle: the toggle uses the old period; the new period applies from the following phase.
//  Counter width PER_W; the compare is against the clamped period, so wrap never exceeds 2^PER_W-1.
//  Reset asserted mid-pulse/blink: immediate return to reset state; no load is pending after release.
// CONFIGURATION
//  BLINK_DEBOUNCE_EN defined: the synchronised key must hold stable for DEBOUNCE_MS consecutive ticks.
//    The debounced level is then edge-detected. Bounces shorter than that produce no load.
//    Load latency is 3 cycles + up to DEBOUNCE_MS ms.
//  Not defined: synchroniser + edge detect only, 3-cycle latency. Each bounce edge is a separate load.
// STRUCTURE
//  Package blink_pkg:
//    mode enum (MODE_OFF/ON/BLINK/ONESHOT, 2 bits);
//    function computing TICK_DIV from CLK_HZ;
//    period clamp function.
//  Sub-module blink_channel (mode/period pending+active regs, ms counter, led reg).
//    Instantiated N_CH times via generate.
//  Top keeps the prescaler, key sync/debounce, sel decode and load_ack.
// TESTING (CLK_HZ=4000 -> TICK_DIV=4, N_CH=4, PER_W=14)
//  1. Reset release, no keys -> led=0000; tick_ms pulses every 4 cycles; load_ack stays 0.
//  2. Load ch1 BLINK period=3 -> load_ack once.
//     led[1] rises 2 cycles later, toggles every 3 ticks (12 cycles); other leds 0.
//  3. ch1 blinking at 3, reload period=5 mid-phase -> current phase still ends at 3 ticks; following phases last 5 ticks.
//  4. Load ch2 ONESHOT period=0 -> led[2] high for exactly 1 tick, then 0.
//     A second load 2 ticks later pulses again.
//  5. Load with sel=5 (out of range; CH_W=2 so drive sel via a wider TB override or N_CH=3) -> no load_ack, no led change.
//     Hold key low 100 cycles -> single load_ack.
//  6. Reset mid-BLINK on ch0 -> led=0 asynchronously. After release ch0 stays OFF.
//     With BLINK_DEBOUNCE_EN, 3-tick key bounce -> no load.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and helpers for the blink_array LED blinker.
package blink_pkg;

  // Per-channel operating mode, encoded exactly as the mode switches are wired.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  // Clock cycles per millisecond tick, never less than one.
  function automatic int calc_tick_div(input int clk_hz);
    int div;
    div = clk_hz / 1000;
    if (div < 1) div = 1;
    return div;
  endfunction

  // A zero period would never terminate a phase, so it behaves as one ms.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: pending (loaded) and active mode/period, ms counter and LED register.
// A load only updates the pending settings; the active settings follow one edge later,
// except a same-mode BLINK reload, whose period is adopted at the next toggle.
module blink_channel
  import blink_pkg::*;
#(
  parameter int PER_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [1:0]       mode_i,
  input  logic [PER_W-1:0] period_i,
  output logic             led_o
);

  mode_e            pend_mode_q, pend_mode_d;
  mode_e            act_mode_q,  act_mode_d;
  logic [PER_W-1:0] pend_per_q,  pend_per_d;
  logic [PER_W-1:0] act_per_q,   act_per_d;
  logic [PER_W-1:0] cnt_q,       cnt_d;
  logic             led_q,       led_d;
  logic             apply_q,     apply_d;

  logic [PER_W-1:0] period_clamped;
  logic             phase_end;
  logic             restart;

  assign period_clamped = PER_W'(clamp_period(32'(period_i)));
  assign phase_end      = (cnt_q == act_per_q - 1'b1);
  // A fresh load restarts the channel when the mode changes; ONESHOT restarts even on a same-mode reload.
  assign restart        = apply_q && ((pend_mode_q != act_mode_q) || (pend_mode_q == MODE_ONESHOT));

  // Next-state for pending settings, active mode, counter and LED.
  always_comb begin
    pend_mode_d = pend_mode_q;
    pend_per_d  = pend_per_q;
    act_mode_d  = act_mode_q;
    act_per_d   = act_per_q;
    cnt_d       = cnt_q;
    led_d       = led_q;
    apply_d     = 1'b0;

    if (load_i) begin
      pend_mode_d = mode_e'(mode_i);
      pend_per_d  = period_clamped;
      apply_d     = 1'b1;
    end

    if (restart) begin
      act_mode_d = pend_mode_q;
      act_per_d  = pend_per_q;
      cnt_d      = '0;
      led_d      = (pend_mode_q != MODE_OFF);
    end else if (tick_i) begin
      case (act_mode_q)
        MODE_BLINK: begin
          if (phase_end) begin
            led_d     = ~led_q;
            cnt_d     = '0;
            // A load landing in the same cycle as the toggle still shapes the next phase.
            act_per_d = pend_per_d;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MODE_ONESHOT: begin
          if (phase_end) begin
            led_d      = 1'b0;
            cnt_d      = '0;
            act_mode_d = MODE_OFF;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_mode_q <= MODE_OFF;
      act_mode_q  <= MODE_OFF;
      pend_per_q  <= PER_W'(1);
      act_per_q   <= PER_W'(1);
      cnt_q       <= '0;
      led_q       <= 1'b0;
      apply_q     <= 1'b0;
    end else begin
      pend_mode_q <= pend_mode_d;
      act_mode_q  <= act_mode_d;
      pend_per_q  <= pend_per_d;
      act_per_q   <= act_per_d;
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      apply_q     <= apply_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/blink_array.sv
// N-channel LED blinker top: shared ms prescaler, key synchroniser/edge detect,
// channel select decode and load acknowledge. Optional key debounce is built
// when BLINK_DEBOUNCE_EN is defined.
module blink_array
  import blink_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_CH        = 4,
  parameter int PER_W       = 14,
  parameter int DEBOUNCE_MS = 8,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load_n,
  input  logic [CH_W-1:0]  sel,
  input  logic [1:0]       mode,
  input  logic [PER_W-1:0] period,
  output logic [N_CH-1:0]  led,
  output logic             tick_ms,
  output logic             load_ack
);

  localparam int TICK_DIV = calc_tick_div(CLK_HZ);
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             key_meta_q, key_sync_q;
  logic             key_lvl;
  logic             key_prev_q;
  logic             load_q;
  logic             ack_q;
  logic             sel_ok;

  assign tick_ms = (presc_q == PRE_LAST);
  assign presc_d = tick_ms ? '0 : presc_q + 1'b1;

  // Millisecond prescaler shared by every channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  // Two-flop synchroniser; idle (released) key reads as 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= key_load_n;
      key_sync_q <= key_meta_q;
    end
  end

`ifdef BLINK_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

  logic            db_level_q, db_level_d;
  logic [DB_W-1:0] db_cnt_q,   db_cnt_d;

  // Accept a new key level only after it has differed for DEBOUNCE_MS consecutive ticks.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    if (key_sync_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (tick_ms) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = key_sync_q;
        db_cnt_d   = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign key_lvl = db_level_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_MS != 0);
  assign key_lvl         = key_sync_q;
`endif

  assign sel_ok = (int'(sel) < N_CH);

  // Falling-edge detect on the key level produces a single-cycle load; ack follows for valid channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_prev_q <= 1'b1;
      load_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      key_prev_q <= key_lvl;
      load_q     <= key_prev_q & ~key_lvl;
      ack_q      <= load_q & sel_ok;
    end
  end

  assign load_ack = ack_q;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic ch_load;
      assign ch_load = load_q && (int'(sel) == gi);

      blink_channel #(
        .PER_W (PER_W)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .tick_i   (tick_ms),
        .load_i   (ch_load),
        .mode_i   (mode),
        .period_i (period),
        .led_o    (led[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_blink_array.sv
// Self-checking bench for blink_array (CLK_HZ=4000 -> 4 cycles per ms, 3 channels so sel=3 is out of range).
module tb_blink_array;

  localparam int CLK_HZ = 4000;
  localparam int N_CH   = 3;
  localparam int PER_W  = 14;
  localparam int CH_W   = 2;

  localparam logic [1:0] M_OFF = 2'b00, M_ON = 2'b01, M_BLINK = 2'b10, M_ONESHOT = 2'b11;

`ifdef BLINK_DEBOUNCE_EN
  localparam int HOLD = 50;
  localparam int WIN  = 45;
`else
  localparam int HOLD = 6;
  localparam int WIN  = 10;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             key_load_n = 1'b1;
  logic [CH_W-1:0]  sel = '0;
  logic [1:0]       mode = '0;
  logic [PER_W-1:0] period = '0;
  logic [N_CH-1:0]  led;
  logic             tick_ms;
  logic             load_ack;

  blink_array #(
    .CLK_HZ      (CLK_HZ),
    .N_CH        (N_CH),
    .PER_W       (PER_W),
    .DEBOUNCE_MS (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_load_n (key_load_n),
    .sel        (sel),
    .mode       (mode),
    .period     (period),
    .led        (led),
    .tick_ms    (tick_ms),
    .load_ack   (load_ack)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Scoreboards: expected ack counts per key press, expected tick widths of ch2 one-shot pulses.
  int exp_ack_q[$];
  int exp_os_q[$];

  logic [N_CH-1:0] led_at_ack, led_after_ack;
  int              ack_lat;

  // Press the key with the given settings, hold it, release it, and score the acks seen.
  task automatic press(input logic [CH_W-1:0] s, input logic [1:0] m, input int p,
                       input int hold, input int exp_acks, input string name);
    int acks;
    int expv;
    bit seen;
    acks = 0;
    seen = 0;
    @(negedge clk);
    sel = s; mode = m; period = PER_W'(p); key_load_n = 1'b0;
    exp_ack_q.push_back(exp_acks);
    ack_lat = -1;
    for (int i = 1; i <= hold + WIN; i++) begin
      @(negedge clk);
      if (seen) begin
        led_after_ack = led;
        seen = 0;
      end
      if (load_ack) begin
        acks++;
        if (ack_lat < 0) begin
          ack_lat    = i;
          led_at_ack = led;
          seen       = 1;
        end
      end
      if (i == hold) key_load_n = 1'b1;
    end
    expv = exp_ack_q.pop_front();
    chk({name, " ack count"}, acks, expv);
  endtask

  // Cycles until the given LED changes; -1 when it does not change within the budget.
  task automatic wait_toggle(input int ch, output int cyc);
    logic prev;
    prev = led[ch];
    cyc  = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (led[ch] != prev) begin
        cyc = n;
        break;
      end
    end
  endtask

  // One-shot monitor on ch2: count ticks while the LED is high and score each pulse when it falls.
  bit watch_os = 0;
  initial begin
    int  os_ticks;
    bit  os_high;
    int  expv;
    os_ticks = 0;
    os_high  = 0;
    forever begin
      @(negedge clk);
      if (watch_os) begin
        if (led[2]) begin
          if (tick_ms) os_ticks++;
        end else if (os_high) begin
          if (exp_os_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL oneshot unexpected pulse: got %0d ticks expected none", os_ticks);
          end else begin
            expv = exp_os_q.pop_front();
            chk("oneshot pulse ticks", os_ticks, expv);
          end
        end
        os_high = led[2];
        if (!led[2]) os_ticks = 0;
      end else begin
        os_high  = 0;
        os_ticks = 0;
      end
    end
  end

  typedef struct {
    logic [CH_W-1:0] sel;
    logic [1:0]      mode;
    int              per;
    int              exp_ack;
    logic [N_CH-1:0] exp_led;
  } vec_t;

  vec_t tbl [9];
  int   c0, c1, c2, c3;

  function automatic logic bounce_key(input int i);
`ifdef BLINK_DEBOUNCE_EN
    return !(i < 12);
`else
    return !((i < 2) || ((i >= 5) && (i < 7)));
`endif
  endfunction

  initial begin
    int acks;
    int first_tick;
    int led_on;
    int bounce_exp;

    tbl[0] = '{2'd0, M_ON,      5, 1, 3'b001};
    tbl[1] = '{2'd2, M_ON,      5, 1, 3'b101};
    tbl[2] = '{2'd3, M_ON,      5, 0, 3'b101};
    tbl[3] = '{2'd0, M_OFF,     5, 1, 3'b100};
    tbl[4] = '{2'd1, M_ON,      0, 1, 3'b110};
    tbl[5] = '{2'd1, M_ON,      7, 1, 3'b110};
    tbl[6] = '{2'd2, M_OFF,     1, 1, 3'b010};
    tbl[7] = '{2'd1, M_OFF,     1, 1, 3'b000};
    tbl[8] = '{2'd3, M_ONESHOT, 2, 0, 3'b000};

    // 1: reset state, idle tick cadence, no spontaneous acks.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset led", int'(led), 0);
    chk("reset load_ack", int'(load_ack), 0);
    chk("reset tick_ms", int'(tick_ms), 0);
    acks = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("idle tick cycle %0d", i), int'(tick_ms), ((i % 4) == 3) ? 1 : 0);
      if (load_ack) acks++;
    end
    chk("idle ack count", acks, 0);

    // Table of single loads: ack presence, ack latency and steady LED pattern.
    for (int k = 0; k < 9; k++) begin
      press(tbl[k].sel, tbl[k].mode, tbl[k].per, HOLD, tbl[k].exp_ack, $sformatf("vec%0d", k));
`ifndef BLINK_DEBOUNCE_EN
      if (tbl[k].exp_ack == 1) chk($sformatf("vec%0d ack latency", k), ack_lat, 4);
`endif
      chk($sformatf("vec%0d led", k), int'(led), int'(tbl[k].exp_led));
    end

    // Key bounce: each edge loads without debounce; a short bounce is rejected with it.
`ifdef BLINK_DEBOUNCE_EN
    bounce_exp = 0;
`else
    bounce_exp = 2;
`endif
    sel = 2'd1; mode = M_OFF; period = PER_W'(1);
    exp_ack_q.push_back(bounce_exp);
    acks = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (load_ack) acks++;
      key_load_n = bounce_key(i);
    end
    chk("bounce ack count", acks, exp_ack_q.pop_front());

    // 2: ch1 BLINK period 3.
    press(2'd1, M_BLINK, 3, HOLD, 1, "t2 blink load");
    chk("t2 led1 at ack", int'(led_at_ack[1]), 0);
    chk("t2 led1 after ack", int'(led_after_ack[1]), 1);
    chk("t2 other leds", int'(led_after_ack & 3'b101), 0);
    wait_toggle(1, c0);
    chk("t2 sync toggle seen", int'(c0 > 0), 1);
    wait_toggle(1, c1);
    chk("t2 phase cycles a", c1, 12);
    wait_toggle(1, c2);
    chk("t2 phase cycles b", c2, 12);
    chk("t2 other leds steady", int'(led & 3'b101), 0);

    // 3: reload period 5 mid-phase; the running phase keeps 3 ticks.
    fork
      press(2'd1, M_BLINK, 5, HOLD, 1, "t3 reload");
      begin
        wait_toggle(1, c1);
        wait_toggle(1, c2);
        wait_toggle(1, c3);
      end
    join
    chk("t3 phase old period", c1, 12);
    chk("t3 phase new period a", c2, 20);
    chk("t3 phase new period b", c3, 20);

    // 4: ch2 ONESHOT with period 0, repeated, then period 3.
    watch_os = 1;
    exp_os_q.push_back(1);
    press(2'd2, M_ONESHOT, 0, HOLD, 1, "t4 oneshot a");
    repeat (8) @(negedge clk);
    exp_os_q.push_back(1);
    press(2'd2, M_ONESHOT, 0, HOLD, 1, "t4 oneshot b");
    repeat (8) @(negedge clk);
    exp_os_q.push_back(3);
    press(2'd2, M_ONESHOT, 3, HOLD, 1, "t4 oneshot c");
    repeat (24) @(negedge clk);
    chk("t4 pulses outstanding", exp_os_q.size(), 0);
    chk("t4 led2 off", int'(led[2]), 0);
    watch_os = 0;

    // 5: long hold gives one load; out-of-range select is ignored.
    press(2'd0, M_ON, 1, 100, 1, "t5 long hold");
    chk("t5 led0 on", int'(led[0]), 1);
    press(2'd3, M_OFF, 1, HOLD, 0, "t5 sel out of range");
    chk("t5 led0/led2 unchanged", int'(led & 3'b101), 1);

    // 6: reset in the middle of a blink.
    press(2'd0, M_BLINK, 2, HOLD, 1, "t6 blink ch0");
    wait_toggle(0, c0);
    chk("t6 ch0 toggles", int'(c0 > 0), 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6 async led clear", int'(led), 0);
    chk("t6 async tick clear", int'(tick_ms), 0);
    chk("t6 async ack clear", int'(load_ack), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    first_tick = -1;
    led_on = 0;
    acks = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((first_tick < 0) && tick_ms) first_tick = i;
      if (led != '0) led_on++;
      if (load_ack) acks++;
    end
    chk("t6 first tick after release", first_tick, 3);
    chk("t6 leds stay off", led_on, 0);
    chk("t6 no pending load", acks, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
